// File: rtl/title_pkg.sv
// Shared constants and types for the title-screen logo motion source.
package title_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 11;

   typedef logic [COORD_W-1:0] coord_t;
   // One spare bit so pos + step never wraps before the edge compare.
   typedef logic [COORD_W:0]   wide_t;

   typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_e;

   // DIR_INC: right on X / down on Y.  DIR_DEC: left on X / up on Y.
   typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

   typedef struct packed {
      coord_t pos;
      dir_e   dir;
      logic   rev;
   } axis_t;

endpackage

// File: rtl/title_scroller_frame_divider.sv
// Counts frame ticks while not held and strobes adv_o once every FRAME_DIV ticks.
module frame_divider #(
   parameter int FRAME_DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic hold_i,
   output logic adv_o
);

   localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      adv_o = 1'b0;
      if (tick_i && !hold_i) begin
         if (cnt_q == CW'(FRAME_DIV - 1)) begin
            cnt_d = '0;
            adv_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/title_scroller.sv
// Title logo motion source: bounces the logo origin once per advance, updating only on frame ticks.
// Define TITLE_VBOUNCE_EN to let the Y axis move and bounce; otherwise Y stays at START_Y.
module title_scroller #(
   parameter int SCREEN_W    = title_pkg::SCREEN_W,
   parameter int SCREEN_H    = title_pkg::SCREEN_H,
   parameter int LOGO_W      = 288,
   parameter int LOGO_H      = 128,
   parameter int GLYPH_PITCH = 128,
   parameter int START_X     = 176,
   parameter int START_Y     = 64,
   parameter int STEP_X      = 4,
   parameter int STEP_Y      = 2,
   parameter int FRAME_DIV   = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        enable,
   output logic [31:0] gX1,
   output logic [31:0] gY1,
   output logic [31:0] uX1,
   output logic [31:0] uY1,
   output logic [31:0] iX1,
   output logic [31:0] iY1,
   output logic        bounce,
   output logic        moving
);

   import title_pkg::*;

   if (LOGO_W > SCREEN_W || LOGO_H > SCREEN_H || FRAME_DIV < 1 || STEP_X < 1 || STEP_Y < 1)
   begin : g_bad_cfg
      $error("title_scroller: illegal geometry, step or divider parameters");
   end

   localparam wide_t  XMAX_W   = wide_t'(SCREEN_W - LOGO_W);
   localparam wide_t  STEP_X_W = wide_t'(STEP_X);
   localparam wide_t  PITCH_W  = wide_t'(GLYPH_PITCH);
   localparam coord_t START_XC = coord_t'(START_X);
   localparam coord_t START_YC = coord_t'(START_Y);

   function automatic axis_t step_axis(input coord_t pos, input dir_e dir,
                                       input wide_t step, input wide_t lim);
      axis_t r;
      wide_t p;
      p     = {1'b0, pos};
      r.pos = pos;
      r.dir = dir;
      r.rev = 1'b0;
      if (dir == DIR_INC) begin
         if (p + step >= lim) begin
            r.pos = lim[COORD_W-1:0];
            r.dir = DIR_DEC;
            r.rev = 1'b1;
         end else begin
            r.pos = pos + step[COORD_W-1:0];
         end
      end else begin
         if (p <= step) begin
            r.pos = '0;
            r.dir = DIR_INC;
            r.rev = 1'b1;
         end else begin
            r.pos = pos - step[COORD_W-1:0];
         end
      end
      return r;
   endfunction

   state_e state_q, state_d;
   coord_t x_q, x_d;
   dir_e   dirx_q, dirx_d;
   wide_t  ux_q, ux_d, ix_q, ix_d;
   logic   bounce_q, bounce_d;
   logic   adv;
   axis_t  ax;
   coord_t y_cur;

`ifdef TITLE_VBOUNCE_EN
   localparam wide_t YMAX_W   = wide_t'(SCREEN_H - LOGO_H);
   localparam wide_t STEP_Y_W = wide_t'(STEP_Y);
   coord_t y_q, y_d;
   dir_e   diry_q, diry_d;
   axis_t  ay;
   assign y_cur = y_q;
`else
   assign y_cur = START_YC;
`endif

   frame_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
      .clk_i  (clock),
      .rst_i  (reset),
      .tick_i (frame_tick),
      .hold_i (state_q != RUN),
      .adv_o  (adv)
   );

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      dirx_d   = dirx_q;
      bounce_d = 1'b0;
      ax       = step_axis(x_q, dirx_q, STEP_X_W, XMAX_W);
`ifdef TITLE_VBOUNCE_EN
      y_d      = y_q;
      diry_d   = diry_q;
      ay       = step_axis(y_q, diry_q, STEP_Y_W, YMAX_W);
`endif
      if (frame_tick) state_d = enable ? RUN : HOLD;
      if (adv) begin
         x_d      = ax.pos;
         dirx_d   = ax.dir;
         bounce_d = ax.rev;
`ifdef TITLE_VBOUNCE_EN
         y_d      = ay.pos;
         diry_d   = ay.dir;
         bounce_d = ax.rev | ay.rev;
`endif
      end
      ux_d = {1'b0, x_d} + PITCH_W;
      ix_d = {1'b0, x_d} + (PITCH_W << 1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= HOLD;
         x_q      <= START_XC;
         dirx_q   <= DIR_INC;
         ux_q     <= {1'b0, START_XC} + PITCH_W;
         ix_q     <= {1'b0, START_XC} + (PITCH_W << 1);
         bounce_q <= 1'b0;
`ifdef TITLE_VBOUNCE_EN
         y_q      <= START_YC;
         diry_q   <= DIR_INC;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         dirx_q   <= dirx_d;
         ux_q     <= ux_d;
         ix_q     <= ix_d;
         bounce_q <= bounce_d;
`ifdef TITLE_VBOUNCE_EN
         y_q      <= y_d;
         diry_q   <= diry_d;
`endif
      end
   end

   assign gX1    = 32'(x_q);
   assign uX1    = 32'(ux_q);
   assign iX1    = 32'(ix_q);
   assign gY1    = 32'(y_cur);
   assign uY1    = 32'(y_cur);
   assign iY1    = 32'(y_cur);
   assign bounce = bounce_q;
   assign moving = (state_q == RUN);

endmodule

// File: tb/tb_title_scroller.sv
// Directed bench for title_scroller: default divider instance plus a FRAME_DIV=3 instance.
module tb_title_scroller;

   logic        clock = 1'b0;
   logic        reset;
   logic        ft, en, ft3, en3;
   logic [31:0] gX1, gY1, uX1, uY1, iX1, iY1;
   logic [31:0] gX3, gY3, uX3, uY3, iX3, iY3;
   logic        bounce, moving, bounce3, moving3;

   int n_chk = 0;
   int n_bad = 0;
   int nb;
   logic ok;

`ifdef TITLE_VBOUNCE_EN
   localparam int Y_AFTER1 = 66;
   localparam int N_BOUNCE = 3;
`else
   localparam int Y_AFTER1 = 64;
   localparam int N_BOUNCE = 2;
`endif

   always #5 clock = ~clock;

   title_scroller dut (
      .clock(clock), .reset(reset), .frame_tick(ft), .enable(en),
      .gX1(gX1), .gY1(gY1), .uX1(uX1), .uY1(uY1), .iX1(iX1), .iY1(iY1),
      .bounce(bounce), .moving(moving)
   );

   title_scroller #(.FRAME_DIV(3)) dut3 (
      .clock(clock), .reset(reset), .frame_tick(ft3), .enable(en3),
      .gX1(gX3), .gY1(gY3), .uX1(uX3), .uY1(uY3), .iX1(iX3), .iY1(iY3),
      .bounce(bounce3), .moving(moving3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock) ft = 1'b1;
      @(negedge clock) ft = 1'b0;
   endtask

   task automatic tick3();
      @(negedge clock) ft3 = 1'b1;
      @(negedge clock) ft3 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ft = 1'b0; en = 1'b0; ft3 = 1'b0; en3 = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_gX", gX1, 176);
      chk("rst_uX", uX1, 304);
      chk("rst_iX", iX1, 432);
      chk("rst_gY", gY1, 64);
      chk("rst_iY", iY1, 64);
      chk("rst_bounce", 32'(bounce), 0);
      chk("rst_moving", 32'(moving), 0);
      reset = 1'b0;
      @(negedge clock);

      en = 1'b1;
      repeat (3) @(negedge clock);
      chk("en_no_tick", 32'(moving), 0);
      tick();
      chk("t1_gX", gX1, 176);
      chk("t1_moving", 32'(moving), 1);
      tick();
      chk("t2_gX", gX1, 180);
      chk("t2_uX", uX1, 308);
      chk("t2_iX", iX1, 436);
      chk("t2_gY", gY1, Y_AFTER1);
      chk("t2_uY", uY1, Y_AFTER1);

      repeat (42) tick();
      chk("pre_right_gX", gX1, 348);
      chk("pre_right_bounce", 32'(bounce), 0);
      tick();
      chk("right_edge_gX", gX1, 352);
      chk("right_edge_bounce", 32'(bounce), 1);
      @(negedge clock);
      chk("bounce_one_cycle", 32'(bounce), 0);
      tick();
      chk("after_right_gX", gX1, 348);

      repeat (86) tick();
      chk("pre_left_gX", gX1, 4);
      tick();
      chk("left_edge_gX", gX1, 0);
      chk("left_edge_bounce", 32'(bounce), 1);
      tick();
      chk("after_left_gX", gX1, 4);
      chk("after_left_bounce", 32'(bounce), 0);

      repeat (5) tick();
      chk("pre_rst_gX", gX1, 24);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_gX", gX1, 176);
      chk("async_rst_iX", iX1, 432);
      chk("async_rst_gY", gY1, 64);
      chk("async_rst_moving", 32'(moving), 0);
      @(negedge clock);
      reset = 1'b0;
      en = 1'b0;

      en3 = 1'b1;
      tick3();
      chk("d3_run", 32'(moving3), 1);
      repeat (3) tick3();
      chk("d3_first_adv", gX3, 180);
      repeat (4) tick3();
      chk("d3_two_adv", gX3, 184);
      en3 = 1'b0;
      tick3();
      chk("d3_hold", 32'(moving3), 0);
      chk("d3_hold_gX", gX3, 184);
      repeat (5) tick3();
      chk("d3_frozen_gX", gX3, 184);

      @(negedge clock) reset = 1'b1;
      @(negedge clock) reset = 1'b0;
      en3 = 1'b1;
      tick3();
      repeat (2) tick3();
      chk("d3_div_cleared", gX3, 176);
      tick3();
      chk("d3_adv_after_rst", gX3, 180);
      en3 = 1'b0;

      en = 1'b1;
      tick();
      nb = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
`ifdef TITLE_VBOUNCE_EN
         ok = (gX1 == 352) || (gX1 == 0) || (gY1 == 352) || (gY1 == 0);
`else
         ok = (gX1 == 352) || (gX1 == 0);
         chk("y_const", gY1, 64);
`endif
         if (bounce) begin
            nb++;
            chk("bounce_pos", 32'(ok), 1);
         end
         if (i == 44) chk("run_right_gX", gX1, 352);
         if (i == 132) chk("run_left_gX", gX1, 0);
      end
      chk("bounce_count", 32'(nb), 32'(N_BOUNCE));
      chk("run_end_gX", gX1, 272);
`ifdef TITLE_VBOUNCE_EN
      chk("run_end_gY", gY1, 240);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
